// File: rtl/ram_bist_pkg.sv
// ram_bist_pkg: shared definitions for the March C- RAM BIST controller.
//   state_e     - controller FSM states
//   elem_e      - March element index M0..M5 (encoding 0..5)
//   elem_cfg_t  - per-element direction / read / write / data-value table
//   elem_cfg()  - table lookup for one element
package ram_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR   = 3'd1,   // write-only step (M0)
        ST_RD   = 3'd2,   // issue read
        ST_CMP  = 3'd3,   // compare read data, issue the element's write if any
        ST_DONE = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        EL_M0 = 3'd0,
        EL_M1 = 3'd1,
        EL_M2 = 3'd2,
        EL_M3 = 3'd3,
        EL_M4 = 3'd4,
        EL_M5 = 3'd5
    } elem_e;

    localparam elem_e LAST_ELEM = EL_M5;

    typedef struct packed {
        logic down;    // 1: walk DEPTH-1 -> 0
        logic rd;      // element starts with a read
        logic wr;      // element contains a write
        logic rd_val;  // expected word: 0 = all zeros, 1 = all ones
        logic wr_val;  // written word:  0 = all zeros, 1 = all ones
    } elem_cfg_t;

    // March C-: up(w0) up(r0,w1) up(r1,w0) down(r0,w1) down(r1,w0) down(r0)
    function automatic elem_cfg_t elem_cfg(input elem_e e);
        case (e)
            EL_M0:   elem_cfg = '{down: 1'b0, rd: 1'b0, wr: 1'b1, rd_val: 1'b0, wr_val: 1'b0};
            EL_M1:   elem_cfg = '{down: 1'b0, rd: 1'b1, wr: 1'b1, rd_val: 1'b0, wr_val: 1'b1};
            EL_M2:   elem_cfg = '{down: 1'b0, rd: 1'b1, wr: 1'b1, rd_val: 1'b1, wr_val: 1'b0};
            EL_M3:   elem_cfg = '{down: 1'b1, rd: 1'b1, wr: 1'b1, rd_val: 1'b0, wr_val: 1'b1};
            EL_M4:   elem_cfg = '{down: 1'b1, rd: 1'b1, wr: 1'b1, rd_val: 1'b1, wr_val: 1'b0};
            default: elem_cfg = '{down: 1'b1, rd: 1'b1, wr: 1'b0, rd_val: 1'b0, wr_val: 1'b0};
        endcase
    endfunction

endpackage

// File: rtl/ram_bist_addr_gen.sv
// ram_bist_addr_gen: up/down address counter for the March walk.
//   clk, resetn  - clock, async active-low reset (address -> 0)
//   load         - load the element's first address (0, or DEPTH-1 if load_down)
//   load_down    - direction of the element being loaded
//   step         - advance one address in direction 'down'
//   down         - direction of the current element
//   addr         - current address
//   last         - current address is the last one of the walk in direction 'down'
module ram_bist_addr_gen #(
    parameter int ADDR  = 8,
    parameter int DEPTH = 8
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            load,
    input  logic            load_down,
    input  logic            step,
    input  logic            down,
    output logic [ADDR-1:0] addr,
    output logic            last
);

    localparam logic [ADDR-1:0] TOP_ADDR = ADDR'(DEPTH - 1);

    logic [ADDR-1:0] addr_d, addr_q;

    always_comb begin
        addr_d = addr_q;
        if (load) begin
            addr_d = load_down ? TOP_ADDR : '0;
        end else if (step) begin
            addr_d = down ? addr_q - 1'b1 : addr_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) addr_q <= '0;
        else         addr_q <= addr_d;
    end

    assign addr = addr_q;
    assign last = down ? (addr_q == '0) : (addr_q == TOP_ADDR);

endmodule

// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl: March C- BIST controller for a single-port synchronous RAM.
//   clk, resetn          - clock (rising edge), async active-low reset
//   start                - level request, sampled only in IDLE
//   busy                 - test in progress (11*DEPTH cycles)
//   done                 - one-cycle pulse at test end
//   fail                 - sticky mismatch flag of the last run
//   ram_cs / ram_rd      - chip select, read(1)/write(0)
//   ram_addr / ram_wdata - access address and write data
//   ram_rdata            - RAM read data, valid the cycle after the read edge
// Optional build macro RAM_BIST_ERRLOG_EN adds err_addr / err_elem / err_count
// (first failing address and element, saturating mismatch count).
module ram_bist_ctrl
    import ram_bist_pkg::*;
#(
    parameter int ADDR  = 8,
    parameter int DATA  = 8,
    parameter int DEPTH = 8
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            fail,
    output logic            ram_cs,
    output logic            ram_rd,
    output logic [ADDR-1:0] ram_addr,
    output logic [DATA-1:0] ram_wdata,
`ifdef RAM_BIST_ERRLOG_EN
    output logic [ADDR-1:0] err_addr,
    output logic [2:0]      err_elem,
    output logic [7:0]      err_count,
`endif
    input  logic [DATA-1:0] ram_rdata
);

    state_e          state_d, state_q;
    elem_e           elem_d, elem_q, elem_nxt;
    logic            fail_d, fail_q;
    logic            busy_d, busy_q;
    logic            done_d, done_q;
    logic            ram_cs_d, ram_cs_q;
    logic            ram_rd_d, ram_rd_q;
    logic [DATA-1:0] ram_wdata_d, ram_wdata_q;
    logic            wr_d;
    logic            mismatch;

    logic            ag_load, ag_load_down, ag_step, ag_last;
    logic [ADDR-1:0] ag_addr;

    ram_bist_addr_gen #(
        .ADDR  (ADDR),
        .DEPTH (DEPTH)
    ) u_addr_gen (
        .clk       (clk),
        .resetn    (resetn),
        .load      (ag_load),
        .load_down (ag_load_down),
        .step      (ag_step),
        .down      (elem_cfg(elem_q).down),
        .addr      (ag_addr),
        .last      (ag_last)
    );

    assign elem_nxt = elem_e'(elem_q + 3'd1);
    // Read data arrives in CMP, one cycle after the RD edge.
    assign mismatch = (state_q == ST_CMP) &&
                      (ram_rdata != {DATA{elem_cfg(elem_q).rd_val}});

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        elem_d       = elem_q;
        fail_d       = fail_q | mismatch;
        ag_load      = 1'b0;
        ag_load_down = 1'b0;
        ag_step      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_WR;
                    elem_d  = EL_M0;
                    fail_d  = 1'b0;
                    ag_load = 1'b1;
                end
            end
            ST_WR: begin
                if (ag_last) begin
                    elem_d       = elem_nxt;
                    state_d      = elem_cfg(elem_nxt).rd ? ST_RD : ST_WR;
                    ag_load      = 1'b1;
                    ag_load_down = elem_cfg(elem_nxt).down;
                end else begin
                    ag_step = 1'b1;
                end
            end
            ST_RD: begin
                state_d = ST_CMP;
            end
            ST_CMP: begin
                if (!ag_last) begin
                    state_d = ST_RD;
                    ag_step = 1'b1;
                end else if (elem_q == LAST_ELEM) begin
                    state_d = ST_DONE;
                end else begin
                    elem_d       = elem_nxt;
                    state_d      = ST_RD;
                    ag_load      = 1'b1;
                    ag_load_down = elem_cfg(elem_nxt).down;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered: decode them from the next state/element.
        wr_d        = (state_d == ST_WR) || ((state_d == ST_CMP) && elem_cfg(elem_d).wr);
        busy_d      = (state_d == ST_WR) || (state_d == ST_RD) || (state_d == ST_CMP);
        done_d      = (state_d == ST_DONE);
        ram_cs_d    = wr_d || (state_d == ST_RD);
        ram_rd_d    = !wr_d;
        ram_wdata_d = wr_d ? {DATA{elem_cfg(elem_d).wr_val}} : '0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            elem_q      <= EL_M0;
            fail_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ram_cs_q    <= 1'b0;
            ram_rd_q    <= 1'b1;
            ram_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            elem_q      <= elem_d;
            fail_q      <= fail_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ram_cs_q    <= ram_cs_d;
            ram_rd_q    <= ram_rd_d;
            ram_wdata_q <= ram_wdata_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign fail      = fail_q;
    assign ram_cs    = ram_cs_q;
    assign ram_rd    = ram_rd_q;
    assign ram_addr  = ag_addr;
    assign ram_wdata = ram_wdata_q;

`ifdef RAM_BIST_ERRLOG_EN
    logic [ADDR-1:0] err_addr_d, err_addr_q;
    logic [2:0]      err_elem_d, err_elem_q;
    logic [7:0]      err_count_d, err_count_q;

    always_comb begin
        err_addr_d  = err_addr_q;
        err_elem_d  = err_elem_q;
        err_count_d = err_count_q;
        if ((state_q == ST_IDLE) && start) begin
            err_addr_d  = '0;
            err_elem_d  = '0;
            err_count_d = '0;
        end else if (mismatch) begin
            // Only the first mismatch of a run is logged.
            if (err_count_q == 8'd0) begin
                err_addr_d = ag_addr;
                err_elem_d = elem_q;
            end
            if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_addr_q  <= '0;
            err_elem_q  <= '0;
            err_count_q <= '0;
        end else begin
            err_addr_q  <= err_addr_d;
            err_elem_q  <= err_elem_d;
            err_count_q <= err_count_d;
        end
    end

    assign err_addr  = err_addr_q;
    assign err_elem  = err_elem_q;
    assign err_count = err_count_q;
`endif

endmodule

// File: doc/ram_bist_ctrl.md
RAM_BIST_CTRL -- requirements
Module: ram_bist_ctrl

Interface
REQ-001 SHALL have parameter ADDR, default 8, meaning the RAM address width.
REQ-002 SHALL have parameter DATA, default 8, meaning the RAM data width.
REQ-003 SHALL have parameter DEPTH, default 8, meaning the number of words tested (addresses 0..DEPTH-1, DEPTH <= 2**ADDR).
REQ-004 SHALL have port clk  input  1  clock (rising edge).
REQ-005 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  input  1  request a test run (level, sampled in IDLE).
REQ-007 SHALL have port busy  output  1  test in progress.
REQ-008 SHALL have port done  output  1  one-cycle pulse at test end.
REQ-009 SHALL have port fail  output  1  sticky mismatch flag for the last run.
REQ-010 SHALL have port ram_cs  output  1  RAM chip select.
REQ-011 SHALL have port ram_rd  output  1  RAM read (1) / write (0).
REQ-012 SHALL have port ram_addr  output  ADDR  RAM address.
REQ-013 SHALL have port ram_wdata  output  DATA  RAM write data.
REQ-014 SHALL have port ram_rdata  input  DATA  RAM read data, registered by the RAM, valid the cycle after a read edge.

Function
REQ-015 SHALL run March C- elements: M0 up(w0); M1 up(r0,w1); M2 up(r1,w0); M3 down(r0,w1); M4 down(r1,w0); M5 down(r0); "0" = all-zeros word, "1" = all-ones word.
REQ-016 SHALL use FSM states IDLE, WR (write-only step), RD (issue read), CMP (compare; issue the element's write if any), DONE.
REQ-017 SHALL, in IDLE with start=1, enter M0 at address 0 the next cycle; busy=1 from that cycle until DONE.
REQ-018 SHALL issue one RAM access per cycle: a read step is RD (ram_cs=1, ram_rd=1) then CMP (ram_rdata compared with the expected word; ram_cs=1, ram_rd=0 for M1-M4; ram_cs=0 for M5).
REQ-019 SHALL take DEPTH cycles for M0 and 2*DEPTH cycles for each of M1-M5, i.e. 11*DEPTH busy cycles in total (88 for DEPTH=8).
REQ-020 SHALL step up elements 0->DEPTH-1 and down elements DEPTH-1->0, then move to the next element without idle cycles.
REQ-021 SHALL set fail on any CMP mismatch, keep it set for the rest of the run, and not abort the run.
REQ-022 SHALL clear fail when a new run starts.
REQ-023 SHALL enter DONE after the last M5 CMP, pulse done for one cycle there with busy=0, and return to IDLE.
REQ-024 SHALL ignore start while busy; a start still high in IDLE after DONE launches a new run.
REQ-025 SHALL drive ram_cs=0 in IDLE and DONE; ram_addr and ram_wdata are don't-care whenever ram_cs=0.

Reset
REQ-026 SHALL, on resetn low at any time including mid-run, force IDLE with busy=0, done=0, fail=0, ram_cs=0, ram_rd=1, ram_addr=0, ram_wdata=0.
REQ-027 SHALL leave the RAM contents undefined after a mid-run reset; the next run rewrites every word in M0.

Configuration
REQ-028 SHALL, with RAM_BIST_ERRLOG_EN defined, add outputs err_addr (ADDR), err_elem (3 bits, element index 0-5) and err_count (8 bits, saturating at 255); these latch the first failing address and element and count all mismatches; all are cleared by reset and at run start.
REQ-029 SHALL, without RAM_BIST_ERRLOG_EN, omit those ports and their registers.

Structure
REQ-030 SHALL take the FSM state enum, the element index encoding (M0-M5) and the per-element direction/read/write/expected-value table from the shared package ram_bist_pkg.
REQ-031 SHALL put the up/down address counter with first/last detection in a sub-module ram_bist_addr_gen.

Verification
REQ-032 SHALL check that with a fault-free RAM, DEPTH=8 and a one-cycle start pulse: busy lasts 88 cycles, done pulses once, and fail=0.
REQ-033 SHALL check that with RAM bit 0 at address 3 stuck at 1: fail=1 at done; with the macro, err_addr=3, err_elem=1 and err_count=3 (mismatches in M1, M3 and M5).
REQ-034 SHALL check that a start pulse at busy cycle 10 changes no output: total 88 busy cycles, a single done pulse.
REQ-035 SHALL check that resetn low at busy cycle 20 gives ram_cs=0 and busy=0 immediately; a later start runs a full 88-cycle pass with fail=0.
REQ-036 SHALL check that start held high gives back-to-back runs, each separated by exactly one DONE cycle and one IDLE cycle, with fail cleared at each run start.
REQ-037 SHALL check the access trace for DEPTH=4: M0 writes 0,1,2,3; M3 accesses addresses 3,3,2,2,1,1,0,0 alternating read and write.
